// File: rtl/mac_acc_pipe.sv
// mac_acc_pipe: pipelined multiply-accumulate with sticky overflow detection.
//
// Each accepted beat forms P = A*B (sign- or zero-extended to W bits) + cin.
// P and its first/last/signed_mode tags travel through PIPE register stages;
// at the pipeline exit the beat either starts a new accumulation or adds into
// the open one. A last-tagged beat publishes the result on sum/ovf with a
// one-cycle out_valid pulse, PIPE+1 cycles after the beat was presented.
//
// Ports:
//   sys_clk      clock, rising edge
//   sys_rst      synchronous active-high reset
//   en           input beat valid (en=0 cycles are bubbles)
//   first        beat starts a new accumulation
//   last         beat ends the accumulation
//   signed_mode  1 = A/B two's complement, 0 = unsigned
//   A, B         operands
//   cin          +1 added to this beat's product
//   sum          final accumulation result (held between pulses)
//   out_valid    one-cycle pulse, sum/ovf valid
//   ovf          accumulation overflowed (held with sum)
//   busy         beat in flight or accumulation open

module mac_acc_pipe #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8,
    parameter int GUARD   = 4,
    parameter int PIPE    = 2,
    parameter int SAT     = 0
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst,
    input  logic                               en,
    input  logic                               first,
    input  logic                               last,
    input  logic                               signed_mode,
    input  logic [WIDTH_A-1:0]                 A,
    input  logic [WIDTH_B-1:0]                 B,
    input  logic                               cin,
    output logic [WIDTH_A+WIDTH_B+GUARD-1:0]   sum,
    output logic                               out_valid,
    output logic                               ovf,
    output logic                               busy
);

    localparam int W  = WIDTH_A + WIDTH_B + GUARD;
    localparam int WP = WIDTH_A + WIDTH_B;

    // ------------------------------------------------------------------
    // Product formation. Operands are extended to the full product width
    // according to the mode, so a single multiplier serves both modes: the
    // low WP bits of the extended product are the exact signed/unsigned
    // product.
    // ------------------------------------------------------------------
    logic [WP-1:0] a_x;
    logic [WP-1:0] b_x;
    logic [WP-1:0] prod;
    logic [W-1:0]  p_in;

    always_comb begin
        a_x  = {{WIDTH_B{signed_mode & A[WIDTH_A-1]}}, A};
        b_x  = {{WIDTH_A{signed_mode & B[WIDTH_B-1]}}, B};
        prod = a_x * b_x;
        p_in = {{GUARD{signed_mode & prod[WP-1]}}, prod} + {{(W-1){1'b0}}, cin};
    end

    // ------------------------------------------------------------------
    // Multiplier pipeline. Tags are gated by en so bubbles carry nothing.
    // ------------------------------------------------------------------
    logic [W-1:0]    p_q [PIPE];
    logic [PIPE-1:0] vld_q;
    logic [PIPE-1:0] fst_q;
    logic [PIPE-1:0] lst_q;
    logic [PIPE-1:0] sgn_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vld_q <= '0;
            fst_q <= '0;
            lst_q <= '0;
            sgn_q <= '0;
            for (int i = 0; i < PIPE; i++) begin
                p_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= en;
            fst_q[0] <= en & first;
            lst_q[0] <= en & last;
            sgn_q[0] <= signed_mode;
            p_q[0]   <= p_in;
            for (int i = 1; i < PIPE; i++) begin
                vld_q[i] <= vld_q[i-1];
                fst_q[i] <= fst_q[i-1];
                lst_q[i] <= lst_q[i-1];
                sgn_q[i] <= sgn_q[i-1];
                p_q[i]   <= p_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator at the pipeline exit.
    // ------------------------------------------------------------------
    logic         x_vld;
    logic         x_fst;
    logic         x_lst;
    logic         x_sgn;
    logic [W-1:0] x_p;

    assign x_vld = vld_q[PIPE-1];
    assign x_fst = fst_q[PIPE-1];
    assign x_lst = lst_q[PIPE-1];
    assign x_sgn = sgn_q[PIPE-1];
    assign x_p   = p_q[PIPE-1];

    logic [W-1:0] acc_q, acc_d;
    logic         open_q, open_d;
    logic         stk_q, stk_d;
    logic [W-1:0] sum_q, sum_d;
    logic         ovf_q, ovf_d;
    logic         out_valid_q, out_valid_d;

    logic         start;
    logic [W-1:0] a_base;
    logic [W:0]   a_ext;
    logic [W:0]   p_ext;
    logic [W:0]   s_ext;
    logic         add_ovf;
    logic [W-1:0] res;
    logic         stk_new;

    always_comb begin
        // A beat with no open accumulation behaves as first, even untagged.
        start   = x_fst | ~open_q;
        a_base  = start ? '0 : acc_q;
        // One extra bit holds the true sum; its relation to bit W-1 gives
        // signed overflow, and it is the carry-out for unsigned.
        a_ext   = {x_sgn & a_base[W-1], a_base};
        p_ext   = {x_sgn & x_p[W-1], x_p};
        s_ext   = a_ext + p_ext;
        add_ovf = x_sgn ? (s_ext[W] ^ s_ext[W-1]) : s_ext[W];

        res = s_ext[W-1:0];
        if (SAT != 0 && add_ovf) begin
            if (!x_sgn) begin
                res = '1;
            end else if (s_ext[W]) begin
                res = {1'b1, {(W-1){1'b0}}};
            end else begin
                res = {1'b0, {(W-1){1'b1}}};
            end
        end

        stk_new = (start ? 1'b0 : stk_q) | add_ovf;

        acc_d       = acc_q;
        open_d      = open_q;
        stk_d       = stk_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;

        if (x_vld) begin
            acc_d  = res;
            stk_d  = stk_new;
            open_d = ~x_lst;
            if (x_lst) begin
                out_valid_d = 1'b1;
                sum_d       = res;
                ovf_d       = stk_new;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            acc_q       <= '0;
            open_q      <= 1'b0;
            stk_q       <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            open_q      <= open_d;
            stk_q       <= stk_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
    assign busy      = (|vld_q) | open_q;

endmodule
